regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Write-back arbiter and scoreboard for the 32×32 MIPS register file. Up to NUM_REQ execution sources (ALU, load unit, multiply/divide unit) compete for the file's single write port. The block grants one source per cycle in round-robin order and drives the file's load_enable / dest_select / reg_data from a registered output stage. It also tracks a per-register busy bit so the issue logic can detect RAW hazards on operandA/operandB reads.

## Interface
- NUM_REQ, 3, number of write-back requesters (2..8)
- DATA_W, 32, write data width
- ADDR_W, 5, register address width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  one clock domain; reset is asynchronous and active-low
- req_valid  in  NUM_REQ  requester i has a write pending
- req_dest  in  NUM_REQ*ADDR_W  packed destination, slice i = requester i
- req_data  in  NUM_REQ*DATA_W  packed write data, slice i = requester i
- req_ready  out  NUM_REQ  one-hot (or zero) grant, combinational
- rsv_valid  in  1  issue logic reserves a destination
- rsv_dest  in  ADDR_W  destination being reserved
- load_enable  out  1  register-file write enable, registered
- dest_select  out  ADDR_W  register-file write address, registered
- reg_data  out  DATA_W  register-file write data, registered
- grant_id  out  clog2(NUM_REQ)  index of requester whose write is on the outputs
- busy  out  2**ADDR_W  scoreboard, bit r = write to r outstanding

## Operation
- **Arbitration**
  - rr_ptr (clog2(NUM_REQ) bits) names the highest-priority requester.
  - Search order: rr_ptr, rr_ptr+1, … with wrap.
  - The first i with req_valid[i]=1 gets req_ready[i]=1. All other ready bits are 0. No valid means no grant.
  - A transfer is req_valid[i] & req_ready[i]. On a transfer edge, rr_ptr ← (i+1) mod NUM_REQ. Otherwise rr_ptr holds.
  - req_ready never depends on downstream state: the port accepts one write every cycle.
  - A requester holds req_dest/req_data stable while valid and not granted.
- **Output stage**
  - On a transfer edge: dest_select ← req_dest[i], reg_data ← req_data[i], grant_id ← i, load_enable ← (req_dest[i] != 0).
  - With no transfer: load_enable ← 0, and dest_select/reg_data/grant_id hold their last values.
  - A write to $zero is accepted and consumed but never produces load_enable.
- **Scoreboard**
  - busy[r] is set on an edge with rsv_valid=1 and rsv_dest=r.
  - busy[r] is cleared on an edge where a transfer with req_dest=r occurs.
  - Set and clear of the same r on the same edge: set wins, so the newer reservation survives.
  - busy[0] is constant 0, and rsv_dest=0 is ignored.
  - Clearing a non-busy register is legal and leaves it 0. The block does not flag it.

## Timing
- Reset (asynchronous assert, synchronous-deassert behaviour assumed from system reset synchroniser):
  - load_enable=0, dest_select=0, reg_data=0, grant_id=0.
  - busy=all 0, rr_ptr=0.
- Reset asserted mid-operation:
  - Any write in the output stage is dropped: load_enable forced 0 immediately.
  - All reservations are lost.
- Latency:
  - Transfer at edge N gives load_enable=1 during cycle N+1.
  - The register file captures at edge N+1, and the value is readable from cycle N+2.
  - busy[r] falls after edge N. Issue logic must therefore forward from reg_data when dest_select matches in cycle N+1. That forwarding is outside this block.
- Throughput: one write per cycle, sustained. With all requesters valid, grants rotate 0,1,2,0,… with no idle cycles.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles.

## Structure
- Shared package `mips_pkg`:
  - NUM_REGS=32, REG_ADDR_W=5, DATA_W=32.
  - Requester ID constants REQ_ALU=0, REQ_LOAD=1, REQ_MULDIV=2.
  - ZERO_REG=5'd0.
- One sub-module, `rr_arbiter` (parameter N), holding:
  - the combinational grant from valid + rr_ptr;
  - the pointer register with its own clk/reset.
- Output register, scoreboard and $zero filtering live in the top level.

## Test plan
- Reset with all inputs active → load_enable=0, busy=0, req_ready=0. After release, the first grant goes to requester 0.
- All three requesters held valid with dests 5,6,7 and data 0xA0/0xA1/0xA2 → req_ready rotates 001,010,100,001. load_enable is high every cycle, with dest_select 5,6,7 one cycle after each grant.
- Requester 1 writes dest 0, data 0xFFFFFFFF → req_ready[1]=1, load_enable stays 0 next cycle, busy unchanged.
- rsv_valid with rsv_dest=9, then a transfer to dest 9 three cycles later → busy[9] is 1 for exactly three cycles, then clears.
- rsv_dest=12 and a transfer to dest 12 on the same edge → busy[12]=1 after the edge, and load_enable=1 with dest_select=12 next cycle.
- Assert reset during the cycle load_enable=1 (dest 3) → load_enable drops to 0 without waiting for clk, and busy is cleared.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared register-file geometry and write-back requester identifiers.
package mips_pkg;
  localparam int NUM_REGS = 32;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {REQ_ALU = 2'd0, REQ_LOAD = 2'd1, REQ_MULDIV = 2'd2} req_id_e;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant with a rotating priority pointer.
module rr_arbiter #(
  parameter int N = 3,
  localparam int IW = $clog2(N)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [N-1:0]  i_valid,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_fire
);
  logic [IW-1:0] r_ptr;
  logic [N-1:0]  w_valid;
  logic          w_hit;
  // Requests are masked while reset is held so nothing is granted during reset.
  assign w_valid = i_valid & {N{i_rst_n}};
  assign o_fire = |w_valid;
  always_comb begin
    o_grant = '0;
    o_idx = '0;
    w_hit = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!w_hit && w_valid[(int'(r_ptr) + k) % N]) begin
        o_grant[(int'(r_ptr) + k) % N] = 1'b1;
        o_idx = IW'((int'(r_ptr) + k) % N);
        w_hit = 1'b1;
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_ptr <= '0;
    else if (o_fire) r_ptr <= (int'(o_idx) == N - 1) ? '0 : o_idx + 1'b1;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin write-back port for the MIPS register file
// with a registered write stage and a per-register busy scoreboard.
module regfile_wb_arbiter import mips_pkg::*; #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = REG_ADDR_W,
  localparam int IW = $clog2(NUM_REQ),
  localparam int NR = 2**ADDR_W
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_dest,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_req_ready,
  input  logic                      i_rsv_valid,
  input  logic [ADDR_W-1:0]         i_rsv_dest,
  output logic                      o_load_enable,
  output logic [ADDR_W-1:0]         o_dest_select,
  output logic [DATA_W-1:0]         o_reg_data,
  output logic [IW-1:0]             o_grant_id,
  output logic [NR-1:0]             o_busy
);
  logic              w_fire;
  logic [IW-1:0]     w_idx;
  logic [ADDR_W-1:0] w_dest;
  logic [DATA_W-1:0] w_data;
  logic [NR-1:0]     w_set, w_clr;
  logic              r_le;
  logic [ADDR_W-1:0] r_dest;
  logic [DATA_W-1:0] r_data;
  logic [IW-1:0]     r_gid;
  logic [NR-1:0]     r_busy;
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_req_valid),
    .o_grant (o_req_ready),
    .o_idx   (w_idx),
    .o_fire  (w_fire)
  );
  assign w_dest = i_req_dest[w_idx*ADDR_W +: ADDR_W];
  assign w_data = i_req_data[w_idx*DATA_W +: DATA_W];
  assign w_set = i_rsv_valid ? NR'(1) << i_rsv_dest : '0;
  assign w_clr = w_fire ? NR'(1) << w_dest : '0;
  // Set is applied after clear so a same-edge reservation survives; bit 0 stays 0.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_le <= 1'b0;
      r_dest <= '0;
      r_data <= '0;
      r_gid <= '0;
      r_busy <= '0;
    end else begin
      r_le <= w_fire && (w_dest != ADDR_W'(ZERO_REG));
      if (w_fire) begin
        r_dest <= w_dest;
        r_data <= w_data;
        r_gid <= w_idx;
      end
      r_busy <= ((r_busy & ~w_clr) | w_set) & ~NR'(1);
    end
  assign o_load_enable = r_le;
  assign o_dest_select = r_dest;
  assign o_reg_data = r_data;
  assign o_grant_id = r_gid;
  assign o_busy = r_busy;
endmodule
